// File: rtl/alu_arbiter.sv
// alu_arbiter: two request/response ports sharing one external single-cycle ALU.
// One operation in flight at a time: IDLE (arbitrate/accept) -> ISSUE (drive ALU)
// -> RESP (hold response until the owning port takes it).
// Build option: define ALU_ARB_RR_EN for round-robin arbitration; without it,
// port 0 has fixed priority and no last-grant pointer exists.
module alu_arbiter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [3:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [3:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [W-1:0] rsp0_result,
    output logic         rsp0_zero,
    output logic         rsp0_err,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp1_result,
    output logic         rsp1_zero,
    output logic         rsp1_err,
    output logic [W-1:0] alu_data1,
    output logic [W-1:0] alu_data2,
    output logic [3:0]   alu_ctrl,
    input  logic [W-1:0] alu_result,
    input  logic         alu_zero
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_t;

    state_t state_q;
    logic   port_q;   // port that owns the operation in flight
    logic   op_ok_q;  // captured op code is one the ALU understands
`ifdef ALU_ARB_RR_EN
    logic   last_q;   // port granted on the most recent accept
`endif

    logic         grant_any;
    logic         grant_port;
    logic [3:0]   sel_op;
    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;
    logic [W-1:0] issue_result;
    logic         issue_zero;
    logic         issue_err;

    function automatic logic op_supported(input logic [3:0] op);
        case (op)
            4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111: op_supported = 1'b1;
            default:                                     op_supported = 1'b0;
        endcase
    endfunction

    // Arbitration among valid ports; grant_port is only meaningful when grant_any is set.
    always_comb begin
        grant_any = req0_valid | req1_valid;
`ifdef ALU_ARB_RR_EN
        if (req0_valid && req1_valid) begin
            grant_port = ~last_q;
        end else begin
            grant_port = ~req0_valid;
        end
`else
        grant_port = ~req0_valid;
`endif
    end

    assign sel_op = grant_port ? req1_op : req0_op;
    assign sel_a  = grant_port ? req1_a  : req0_a;
    assign sel_b  = grant_port ? req1_b  : req0_b;

    // Ready only for the granted port, only in IDLE, never while reset is asserted.
    assign req0_ready = rst_n && (state_q == StIdle) && grant_any && !grant_port;
    assign req1_ready = rst_n && (state_q == StIdle) && grant_any && grant_port;

    // Response value for the op in ISSUE; unsupported ops ignore the ALU entirely.
    always_comb begin
        if (op_ok_q) begin
            issue_result = alu_result;
            issue_zero   = alu_zero;
            issue_err    = 1'b0;
        end else begin
            issue_result = '0;
            issue_zero   = 1'b1;
            issue_err    = 1'b1;
        end
    end

    // Control FSM with registered ALU drive and response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            port_q      <= 1'b0;
            op_ok_q     <= 1'b0;
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp0_zero   <= 1'b0;
            rsp0_err    <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
            rsp1_zero   <= 1'b0;
            rsp1_err    <= 1'b0;
            alu_data1   <= '0;
            alu_data2   <= '0;
            alu_ctrl    <= 4'b0000;
`ifdef ALU_ARB_RR_EN
            last_q      <= 1'b1;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant_any) begin
                        port_q    <= grant_port;
                        op_ok_q   <= op_supported(sel_op);
                        alu_data1 <= sel_a;
                        alu_data2 <= sel_b;
                        // An unknown code is never forwarded to the ALU.
                        alu_ctrl  <= op_supported(sel_op) ? sel_op : 4'b0000;
`ifdef ALU_ARB_RR_EN
                        last_q    <= grant_port;
`endif
                        state_q   <= StIssue;
                    end
                end
                StIssue: begin
                    alu_data1 <= '0;
                    alu_data2 <= '0;
                    alu_ctrl  <= 4'b0000;
                    if (port_q) begin
                        rsp1_valid  <= 1'b1;
                        rsp1_result <= issue_result;
                        rsp1_zero   <= issue_zero;
                        rsp1_err    <= issue_err;
                    end else begin
                        rsp0_valid  <= 1'b1;
                        rsp0_result <= issue_result;
                        rsp0_zero   <= issue_zero;
                        rsp0_err    <= issue_err;
                    end
                    state_q <= StResp;
                end
                StResp: begin
                    if (!port_q && rsp0_ready) begin
                        rsp0_valid <= 1'b0;
                        state_q    <= StIdle;
                    end else if (port_q && rsp1_ready) begin
                        rsp1_valid <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks with literal expectations plus a randomized run
// compared every cycle against a transaction-level model of the arbiter.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
    logic        rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
    logic [31:0] rsp0_result, rsp1_result;
    logic [31:0] alu_data1, alu_data2, alu_result;
    logic [3:0]  alu_ctrl;
    logic        alu_zero;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    alu_arbiter #(.W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared ALU stand-in; unknown codes return junk so ignoring it is observable.
    always_comb begin
        case (alu_ctrl)
            4'b0010: alu_result = alu_data1 + alu_data2;
            4'b0110: alu_result = alu_data1 - alu_data2;
            4'b0000: alu_result = alu_data1 & alu_data2;
            4'b0001: alu_result = alu_data1 | alu_data2;
            4'b0111: alu_result = {31'b0, $signed(alu_data1) < $signed(alu_data2)};
            default: alu_result = 32'hdead_beef;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic chk1(input string nm, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Expected {err, zero, result} for one request.
    function automatic logic [33:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] r;
        logic        bad;
        bad = 1'b0;
        case (op)
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0111: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: begin r = 32'd0; bad = 1'b1; end
        endcase
        return {bad, (r == 32'd0), r};
    endfunction

    // Transaction model: idle / accepted-N-cycles-ago / waiting for consumer.
    bit          m_ok = 0;
    bit          m_busy;
    int          m_age;
    logic        m_port;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b;
    logic [33:0] m_exp;
`ifdef ALU_ARB_RR_EN
    logic        m_last;
`endif

    always @(negedge clk) begin : cmp
        logic g_any, g_port;
        g_any = req0_valid | req1_valid;
        if (req0_valid && !req1_valid)      g_port = 1'b0;
        else if (!req0_valid && req1_valid) g_port = 1'b1;
        else begin
`ifdef ALU_ARB_RR_EN
            g_port = (m_last == 1'b1) ? 1'b0 : 1'b1;
`else
            g_port = 1'b0;
`endif
        end

        if (!rst_n) begin
            chk1("rst_ready0", req0_ready, 1'b0);
            chk1("rst_ready1", req1_ready, 1'b0);
        end else if (m_ok) begin
            if (!m_busy) begin
                chk1("idle_ready0", req0_ready, g_any && (g_port == 1'b0));
                chk1("idle_ready1", req1_ready, g_any && (g_port == 1'b1));
                chk1("idle_rsp0_valid", rsp0_valid, 1'b0);
                chk1("idle_rsp1_valid", rsp1_valid, 1'b0);
                chk32("idle_alu_data1", alu_data1, 32'd0);
                chk32("idle_alu_data2", alu_data2, 32'd0);
                chk32("idle_alu_ctrl", 32'(alu_ctrl), 32'd0);
            end else if (m_age == 1) begin
                chk1("issue_ready0", req0_ready, 1'b0);
                chk1("issue_ready1", req1_ready, 1'b0);
                chk1("issue_rsp0_valid", rsp0_valid, 1'b0);
                chk1("issue_rsp1_valid", rsp1_valid, 1'b0);
                chk32("issue_alu_data1", alu_data1, m_a);
                chk32("issue_alu_data2", alu_data2, m_b);
                if (m_exp[33]) chk1("issue_ctrl_not_1111", alu_ctrl == 4'b1111, 1'b0);
                else           chk32("issue_alu_ctrl", 32'(alu_ctrl), 32'(m_op));
            end else begin
                chk1("resp_ready0", req0_ready, 1'b0);
                chk1("resp_ready1", req1_ready, 1'b0);
                chk1("resp_rsp0_valid", rsp0_valid, m_port == 1'b0);
                chk1("resp_rsp1_valid", rsp1_valid, m_port == 1'b1);
                chk32("resp_alu_ctrl", 32'(alu_ctrl), 32'd0);
                if (m_port == 1'b0) begin
                    chk32("rsp0_result", rsp0_result, m_exp[31:0]);
                    chk1("rsp0_zero", rsp0_zero, m_exp[32]);
                    chk1("rsp0_err", rsp0_err, m_exp[33]);
                end else begin
                    chk32("rsp1_result", rsp1_result, m_exp[31:0]);
                    chk1("rsp1_zero", rsp1_zero, m_exp[32]);
                    chk1("rsp1_err", rsp1_err, m_exp[33]);
                end
            end
        end

        // Advance the model across the coming rising edge.
        if (!rst_n) begin
            m_ok   = 1;
            m_busy = 0;
`ifdef ALU_ARB_RR_EN
            m_last = 1'b1;
`endif
        end else if (m_ok) begin
            if (!m_busy) begin
                if (g_any) begin
                    m_port = g_port;
                    m_op   = g_port ? req1_op : req0_op;
                    m_a    = g_port ? req1_a : req0_a;
                    m_b    = g_port ? req1_b : req0_b;
                    m_exp  = ref_op(m_op, m_a, m_b);
                    m_busy = 1;
                    m_age  = 1;
`ifdef ALU_ARB_RR_EN
                    m_last = g_port;
`endif
                end
            end else if (m_age == 1) begin
                m_age = 2;
            end else if ((m_port == 1'b0 && rsp0_ready) || (m_port == 1'b1 && rsp1_ready)) begin
                m_busy = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One op on one port with rsp ready held high; reports result and latency.
    task automatic do_op(input int port, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] res, output logic z,
                         output logic e, output int lat);
        int t0;
        bit acc;
        acc = 0; t0 = 0; lat = -1; res = '0; z = 1'b0; e = 1'b0;
        if (port == 0) begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
        else           begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if ((port == 0) ? req0_ready : req1_ready) begin acc = 1; t0 = cyc; end
        end
        chk1("op_accepted", acc, 1'b1);
        tick();
        req0_valid = 0; req1_valid = 0;
        req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            @(negedge clk);
            if ((port == 0) ? rsp0_valid : rsp1_valid) begin
                lat = cyc - t0;
                res = (port == 0) ? rsp0_result : rsp1_result;
                z   = (port == 0) ? rsp0_zero : rsp1_zero;
                e   = (port == 0) ? rsp0_err : rsp1_err;
            end
        end
        chk1("rsp_seen", lat >= 0, 1'b1);
        tick();
    endtask

    logic [3:0] ops [5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};

    initial begin
        logic [31:0] res;
        logic        z, e, seen;
        int          lat, ng;
        int          grants [4];
        int          exp_g  [4];

        rst_n = 0;
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        rsp0_ready = 1; rsp1_ready = 1;

        // Pin the model to hand-computed values.
        chk32("pin_add", ref_op(4'b0010, 32'd5, 32'd7)[31:0], 32'd12);
        chk1("pin_sub_zero", ref_op(4'b0110, 32'd9, 32'd9)[32], 1'b1);
        chk32("pin_slt_neg", ref_op(4'b0111, 32'hffff_ffff, 32'd1)[31:0], 32'd1);
        chk1("pin_bad_err", ref_op(4'b1111, 32'd1, 32'd2)[33], 1'b1);

        @(posedge clk);
        @(negedge clk);
        chk1("reset_rsp0_valid", rsp0_valid, 1'b0);
        chk1("reset_rsp1_valid", rsp1_valid, 1'b0);
        chk32("reset_rsp0_result", rsp0_result, 32'd0);
        chk32("reset_rsp1_result", rsp1_result, 32'd0);
        chk1("reset_rsp0_zero", rsp0_zero, 1'b0);
        chk1("reset_rsp1_err", rsp1_err, 1'b0);
        chk32("reset_alu_data1", alu_data1, 32'd0);
        chk32("reset_alu_ctrl", 32'(alu_ctrl), 32'd0);
        tick();
        rst_n = 1;
        tick();

        do_op(0, 4'b0010, 32'd5, 32'd7, res, z, e, lat);
        chk32("add_latency", lat, 32'd2);
        chk32("add_result", res, 32'd12);
        chk1("add_zero", z, 1'b0);
        chk1("add_err", e, 1'b0);

        do_op(1, 4'b0110, 32'd9, 32'd9, res, z, e, lat);
        chk32("sub_result", res, 32'd0);
        chk1("sub_zero", z, 1'b1);

        do_op(1, 4'b0111, 32'd3, 32'd4, res, z, e, lat);
        chk32("slt_result", res, 32'd1);
        chk1("slt_zero", z, 1'b0);

        // Both ports valid continuously; last grant was port 1.
        req0_valid = 1; req0_op = 4'b0010; req0_a = 32'd1; req0_b = 32'd2;
        req1_valid = 1; req1_op = 4'b0001; req1_a = 32'd4; req1_b = 32'd8;
        ng = 0;
        for (int i = 0; i < 60 && ng < 4; i++) begin
            @(negedge clk);
            if (req0_ready) begin grants[ng] = 0; ng++; end
            else if (req1_ready) begin grants[ng] = 1; ng++; end
        end
        tick();
        req0_valid = 0; req1_valid = 0;
`ifdef ALU_ARB_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        chk32("grant_count", ng, 32'd4);
        for (int i = 0; i < ng; i++) chk32("grant_seq", grants[i], exp_g[i]);
        repeat (4) tick();

        do_op(0, 4'b1111, 32'd1, 32'd2, res, z, e, lat);
        chk32("bad_result", res, 32'd0);
        chk1("bad_zero", z, 1'b1);
        chk1("bad_err", e, 1'b1);

        // Consumer stall on port 0 with port 1 knocking.
        rsp0_ready = 0;
        req0_valid = 1; req0_op = 4'b0010; req0_a = 32'd100; req0_b = 32'd23;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = req0_ready; end
        tick();
        req0_valid = 0;
        req1_valid = 1; req1_op = 4'b0010; req1_a = 32'd1; req1_b = 32'd1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = rsp0_valid; end
        chk1("stall_rsp_seen", seen, 1'b1);
        repeat (5) begin
            @(negedge clk);
            chk1("stall_rsp0_valid", rsp0_valid, 1'b1);
            chk32("stall_result", rsp0_result, 32'd123);
            chk1("stall_req1_ready", req1_ready, 1'b0);
        end
        tick();
        rsp0_ready = 1;
        tick();
        @(negedge clk);
        chk1("release_rsp0_valid", rsp0_valid, 1'b0);
        chk1("release_idle_ready1", req1_ready, 1'b1);
        tick();
        req1_valid = 0;
        repeat (4) tick();

        // Reset while the op sits in ISSUE.
        req1_valid = 1; req1_op = 4'b0010; req1_a = 32'd6; req1_b = 32'd6;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = req1_ready; end
        tick();
        req1_valid = 0;
        rst_n = 0;
        tick();
        rst_n = 1;
        req0_valid = 1; req1_valid = 1;
        @(negedge clk);
        chk1("abort_rsp1_valid", rsp1_valid, 1'b0);
        chk1("abort_rsp0_valid", rsp0_valid, 1'b0);
        chk1("abort_grant0", req0_ready, 1'b1);
        chk1("abort_grant1", req1_ready, 1'b0);
        tick();
        req0_valid = 0; req1_valid = 0;
        repeat (5) begin
            @(negedge clk);
            chk1("abort_no_rsp1", rsp1_valid, 1'b0);
        end
        tick();

        // Randomized traffic; the compare process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            rst_n      = ($urandom_range(0, 199) != 0);
            req0_valid = $urandom_range(0, 1) == 1;
            req1_valid = $urandom_range(0, 1) == 1;
            req0_op    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : ops[$urandom_range(0, 4)];
            req1_op    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : ops[$urandom_range(0, 4)];
            req0_a     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            req0_b     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            req1_a     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            req1_b     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            rsp0_ready = $urandom_range(0, 3) != 0;
            rsp1_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        rst_n = 1; req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: W, 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  one clock; reset is synchronous and active-low.
REQ-004 req0_valid / req1_valid  input  1  port N request pending.
REQ-005 req0_ready / req1_ready  output  1  port N request accepted this cycle.
REQ-006 req0_op / req1_op  input  4  ALU control code: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  W  operands (a = data1, b = data2).
REQ-008 rsp0_valid / rsp1_valid  output  1  port N response held.
REQ-009 rsp0_ready / rsp1_ready  input  1  port N consumer takes response.
REQ-010 rsp0_result / rsp1_result  output  W  registered ALU result.
REQ-011 rsp0_zero / rsp1_zero  output  1  registered zero flag.
REQ-012 rsp0_err / rsp1_err  output  1  unsupported op code flag.
REQ-013 alu_data1, alu_data2  output  W  operands driven to shared ALU.
REQ-014 alu_ctrl  output  4  control code driven to shared ALU.
REQ-015 alu_result  input  W, alu_zero  input  1  combinational ALU outputs.

Function
REQ-016 FSM states IDLE, ISSUE, RESP; one operation outstanding at a time.
REQ-017 IDLE: grant = combinational pick among valid ports; reqN_ready = 1 only for the granted port, 0 otherwise; ready is 0 in ISSUE and RESP.
REQ-018 Accept (valid & ready) in IDLE captures op, a, b and port id into registers; next state ISSUE.
REQ-019 No valid request in IDLE: stay IDLE, grant pointer unchanged.
REQ-020 ISSUE (exactly one cycle): alu_data1/alu_data2/alu_ctrl driven from captured registers; alu_result and alu_zero sampled at end of cycle into response registers; next state RESP.
REQ-021 Outside ISSUE, alu_data1, alu_data2, alu_ctrl are driven 0.
REQ-022 Unsupported op code: captured result = 0, zero = 1, err = 1, ALU outputs ignored; otherwise err = 0.
REQ-023 RESP: rspN_valid = 1 for the captured port only; result/zero/err stable until handshake.
REQ-024 RESP with rspN_ready = 1: rspN_valid drops next cycle, state IDLE; no accept in the same cycle as a response handshake.
REQ-025 rspN_ready on the non-owning port, or in IDLE/ISSUE, has no effect.
REQ-026 Latency: accept in cycle T -> rspN_valid high in cycle T+2; peak throughput one op per 3 cycles.
REQ-027 Request inputs may change while not accepted; only values at the accept edge are used.

Reset
REQ-028 rst_n low at a rising edge: state IDLE, all rsp*_valid = 0, rsp*_result = 0, rsp*_zero = 0, rsp*_err = 0, alu_* outputs = 0, last-grant pointer = port 1.
REQ-029 Reset in ISSUE or RESP aborts the operation; no response is ever produced for it.
REQ-030 reqN_ready = 0 while rst_n is low.

Configuration
REQ-031 Macro ALU_ARB_RR_EN defined: round-robin; with both valid, grant goes to port not granted last; pointer updates on every accept.
REQ-032 ALU_ARB_RR_EN undefined: fixed priority, port 0 always wins when both valid; pointer logic absent.

Verification
REQ-033 Port 0 add a=5 b=7, rsp0_ready=1 -> rsp0_valid at T+2, result 12, zero 0, err 0; rsp1_valid stays 0.
REQ-034 Port 1 sub a=9 b=9 -> rsp1_result 0, zero 1; port 1 slt a=3 b=4 -> result 1, zero 0.
REQ-035 Both ports valid continuously, 4 ops, RR build -> grants 0,1,0,1; fixed build -> grants 0,0,0,0.
REQ-036 Port 0 op 1111 -> rsp0_result 0, zero 1, err 1; alu_ctrl never driven 1111.
REQ-037 rsp0_ready held 0 for 5 cycles in RESP -> result stable, req ready 0 throughout; release -> IDLE next cycle.
REQ-038 rst_n low during ISSUE -> next cycle IDLE, no rsp valid, next accept grants port 0.
